// File: rtl/window_line_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// window_line_ctrl_pkg
// Shared definitions for the 3x3 window line-buffer control path:
//   - sequencing state encoding (3 bits)
//   - default image geometry and counter width
//   - helper that tells whether a state is streaming pixels into the FIFOs
// ---------------------------------------------------------------------------
package window_line_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL1 = 3'd1,
    ST_FILL2 = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } line_state_e;

  localparam int unsigned DEF_IMAGE_WIDTH = 258;
  localparam int unsigned DEF_CNT_WIDTH   = 16;

  // States in which incoming pixels are written to the line FIFOs.
  function automatic logic is_active(input line_state_e s);
    return (s == ST_FILL1) || (s == ST_FILL2) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Registers the video syncs and derives the per-cycle sync events used by
// the pipeline stages.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_h_sync       : line active (high during pixels)
//   i_v_sync       : frame active (high during frame)
//   o_act_d        : (h & v) delayed one cycle
//   o_line_end     : last pixel of a line was the previous cycle, frame still on
//   o_vs_rise      : frame start
//   o_vs_fall      : frame end
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_h_sync,
  input  logic i_v_sync,
  output logic o_act_d,
  output logic o_line_end,
  output logic o_vs_rise,
  output logic o_vs_fall
);

  logic act;
  logic v_d;

  assign act = i_h_sync & i_v_sync;

  // v_d comes out of reset high so that a frame already in progress at
  // release does not look like a frame start; only a genuine low-to-high
  // transition of i_v_sync afterwards produces o_vs_rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_act_d <= 1'b0;
      v_d     <= 1'b1;
    end else begin
      o_act_d <= act;
      v_d     <= i_v_sync;
    end
  end

  assign o_line_end = o_act_d & ~act & i_v_sync;
  assign o_vs_rise  = i_v_sync & ~v_d;
  assign o_vs_fall  = ~i_v_sync & v_d;

endmodule

// File: rtl/window_line_ctrl.sv
// ---------------------------------------------------------------------------
// window_line_ctrl
// Sequencing controller for the 3x3 line-buffer window datapath (two
// cascaded line FIFOs + three 3-tap shift rows). Tracks frame/line/column
// position from the syncs, drives the FIFO enables through the fill-1,
// fill-2 and run phases, qualifies the output window and flags malformed
// lines.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no tracked frame; wait for frame start
//   FILL1 | first line of the frame is written into FIFO1
//   FILL2 | second line: FIFO1 pops into FIFO2 while refilling
//   RUN   | all three rows live; windows are produced
//   ERR   | a line had the wrong length; frame ignored until it ends
//
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_h_sync, i_v_sync : line / frame active
//   o_fifo_clr         : one-cycle clear to both line FIFOs at frame start
//   o_wr_en1           : write pixel into FIFO1
//   o_rd_en1           : pop FIFO1 (also FIFO2 write enable)
//   o_rd_en2           : pop FIFO2
//   o_win_valid        : 3x3 window at the datapath output is valid
//   o_win_hs, o_win_vs : output line / frame active
//   o_col_cnt          : index of the pixel currently driving the enables
//   o_row_cnt          : completed lines in the current frame
//   o_frame_done       : pulse after the end of a frame that reached RUN
//   o_len_err          : pulse when a line length differs from the image width
// ---------------------------------------------------------------------------
module window_line_ctrl
  import window_line_ctrl_pkg::*;
#(
  parameter int unsigned P_IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int unsigned P_CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_h_sync,
  input  logic                   i_v_sync,
  output logic                   o_fifo_clr,
  output logic                   o_wr_en1,
  output logic                   o_rd_en1,
  output logic                   o_rd_en2,
  output logic                   o_win_valid,
  output logic                   o_win_hs,
  output logic                   o_win_vs,
  output logic [P_CNT_WIDTH-1:0] o_col_cnt,
  output logic [P_CNT_WIDTH-1:0] o_row_cnt,
  output logic                   o_frame_done,
  output logic                   o_len_err
);

  if ((P_IMAGE_WIDTH < 3) || ((P_IMAGE_WIDTH >> P_CNT_WIDTH) != 0)) begin : g_bad_width
    $error("window_line_ctrl: P_IMAGE_WIDTH must be >= 3 and fit in P_CNT_WIDTH bits");
  end

  localparam logic [P_CNT_WIDTH-1:0] LP_W   = P_CNT_WIDTH'(P_IMAGE_WIDTH);
  localparam logic [P_CNT_WIDTH-1:0] LP_ONE = P_CNT_WIDTH'(1);
  localparam logic [P_CNT_WIDTH-1:0] LP_TWO = P_CNT_WIDTH'(2);

  logic act;
  logic act_d;
  logic line_end;
  logic vs_rise;
  logic vs_fall;

  sync_edge_det u_sync (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_h_sync   (i_h_sync),
    .i_v_sync   (i_v_sync),
    .o_act_d    (act_d),
    .o_line_end (line_end),
    .o_vs_rise  (vs_rise),
    .o_vs_fall  (vs_fall)
  );

  assign act = i_h_sync & i_v_sync;

  line_state_e            state;
  line_state_e            state_nxt;
  logic                   len_err_nxt;
  logic                   row_inc;
  logic                   len_ok;
  logic                   ovr;
  logic                   px_ok;
  // Pixels seen so far in the current line (saturates at the image width).
  logic [P_CNT_WIDTH-1:0] pix_cnt;

  assign len_ok = (pix_cnt == LP_W);
  // A pixel beyond the image width can only continue an unbroken run,
  // since any gap ends the line and clears pix_cnt.
  assign ovr    = act & act_d & len_ok;
  assign px_ok  = act & ~ovr & is_active(state);

  always_comb begin
    state_nxt   = state;
    len_err_nxt = 1'b0;
    row_inc     = 1'b0;
    if (vs_fall) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vs_rise) state_nxt = ST_FILL1;
        end
        ST_FILL1, ST_FILL2, ST_RUN: begin
          if (line_end) begin
            if (len_ok) begin
              row_inc   = 1'b1;
              state_nxt = (state == ST_FILL1) ? ST_FILL2 : ST_RUN;
            end else begin
              state_nxt   = ST_ERR;
              len_err_nxt = 1'b1;
            end
          end else if (ovr) begin
            state_nxt   = ST_ERR;
            len_err_nxt = 1'b1;
          end
        end
        ST_ERR: begin
          state_nxt = ST_ERR;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fifo_clr   <= 1'b0;
      o_wr_en1     <= 1'b0;
      o_rd_en1     <= 1'b0;
      o_rd_en2     <= 1'b0;
      o_win_valid  <= 1'b0;
      o_win_vs     <= 1'b0;
      o_frame_done <= 1'b0;
      o_len_err    <= 1'b0;
    end else begin
      o_fifo_clr   <= vs_rise & (state == ST_IDLE);
      o_wr_en1     <= px_ok;
      o_rd_en1     <= px_ok & ((state == ST_FILL2) || (state == ST_RUN));
      o_rd_en2     <= px_ok & (state == ST_RUN);
      // The window for column c is complete one cycle after the pixel at
      // column c has been pushed through the FIFOs.
      o_win_valid  <= o_rd_en2 & (o_col_cnt >= LP_TWO);
      // Only frames that are being tracked propagate to the output syncs.
      o_win_vs     <= i_v_sync & ((state != ST_IDLE) | vs_rise);
      o_frame_done <= vs_fall & (state == ST_RUN);
      o_len_err    <= len_err_nxt;
    end
  end

  assign o_win_hs = o_win_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_cnt   <= '0;
      o_col_cnt <= '0;
      o_row_cnt <= '0;
    end else if (vs_rise) begin
      pix_cnt   <= '0;
      o_col_cnt <= '0;
      o_row_cnt <= '0;
    end else if (state != ST_IDLE) begin
      if (line_end) begin
        pix_cnt   <= '0;
        o_col_cnt <= '0;
      end else if (act) begin
        o_col_cnt <= pix_cnt;
        if (!len_ok) pix_cnt <= pix_cnt + LP_ONE;
      end
      if (row_inc && !(&o_row_cnt)) o_row_cnt <= o_row_cnt + LP_ONE;
    end
  end

endmodule

// File: tb/tb_window_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_window_line_ctrl
// Self-checking bench for window_line_ctrl at an image width of 8. Lines and
// frames are driven from tasks; a monitor accumulates what the DUT emits and
// a line-level reference model predicts per-line enable/valid/error counts
// and per-frame status.
// ---------------------------------------------------------------------------
module tb_window_line_ctrl;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_sync = 1'b0;
  logic          v_sync = 1'b0;
  logic          fifo_clr, wr_en1, rd_en1, rd_en2, win_valid, win_hs, win_vs;
  logic          frame_done, len_err;
  logic [CW-1:0] col_cnt, row_cnt;

  always #5 clk = ~clk;

  window_line_ctrl #(.P_IMAGE_WIDTH(W), .P_CNT_WIDTH(CW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_h_sync     (h_sync),
    .i_v_sync     (v_sync),
    .o_fifo_clr   (fifo_clr),
    .o_wr_en1     (wr_en1),
    .o_rd_en1     (rd_en1),
    .o_rd_en2     (rd_en2),
    .o_win_valid  (win_valid),
    .o_win_hs     (win_hs),
    .o_win_vs     (win_vs),
    .o_col_cnt    (col_cnt),
    .o_row_cnt    (row_cnt),
    .o_frame_done (frame_done),
    .o_len_err    (len_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: cumulative counts, sampled away from the active edge.
  int mon_cyc = 0;
  int m_wr = 0, m_rd1 = 0, m_rd2 = 0, m_val = 0, m_lerr = 0;
  int m_clr = 0, m_done = 0, m_vs = 0, m_hsbad = 0, m_colbad = 0;
  int first_en = 0, first_val = 0, last_val = 0, lerr_cyc = 0;
  // Snapshots taken by the driver at each check point.
  int s_wr = 0, s_rd1 = 0, s_rd2 = 0, s_val = 0, s_lerr = 0;
  int s_clr = 0, s_done = 0, s_vs = 0, s_hsbad = 0, s_colbad = 0;

  always @(negedge clk) begin
    mon_cyc++;
    if (wr_en1) begin
      if (m_wr == s_wr) first_en = mon_cyc;
      if (int'(col_cnt) != (m_wr - s_wr)) m_colbad++;
      m_wr++;
    end
    if (rd_en1) m_rd1++;
    if (rd_en2) m_rd2++;
    if (win_valid) begin
      if (m_val == s_val) first_val = mon_cyc;
      last_val = mon_cyc;
      m_val++;
    end
    if (len_err) begin
      lerr_cyc = mon_cyc;
      m_lerr++;
    end
    if (fifo_clr) m_clr++;
    if (frame_done) m_done++;
    if (win_vs) m_vs++;
    if (win_hs !== win_valid) m_hsbad++;
  end

  // Reference model state: is the frame tracked, has it errored, and how
  // many correct-length lines have been accepted so far.
  bit md_trk = 1'b0;
  bit md_err = 1'b0;
  int md_good = 0;
  int v_ticks = 0;

  task automatic snap_line();
    s_wr = m_wr; s_rd1 = m_rd1; s_rd2 = m_rd2; s_val = m_val; s_lerr = m_lerr;
    s_colbad = m_colbad;
  endtask

  task automatic snap_all();
    snap_line();
    s_clr = m_clr; s_done = m_done; s_vs = m_vs; s_hsbad = m_hsbad;
    v_ticks = 0;
  endtask

  task automatic tick(input logic h, input logic v);
    @(posedge clk);
    #1;
    h_sync = h;
    v_sync = v;
    if (v) v_ticks++;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {63'd0, |{fifo_clr, wr_en1, rd_en1, rd_en2, win_valid, win_hs, win_vs,
                       frame_done, len_err, col_cnt, row_cnt}}, 64'd0);
  endtask

  task automatic start_frame(input int pre);
    md_trk  = 1'b1;
    md_err  = 1'b0;
    md_good = 0;
    for (int i = 0; i < pre; i++) tick(1'b0, 1'b1);
  endtask

  // n pixels, then gap idle cycles; with drop the syncs fall together with
  // the end of the line and the gap cycles are outside the frame.
  task automatic drive_line(input int n, input int gap, input bit drop);
    bit act_m, e_lerr;
    int en, e_rd1, e_rd2, e_val;
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < gap; i++) tick(1'b0, !drop);
    @(negedge clk);
    #1;
    act_m  = md_trk && !md_err;
    en     = act_m ? ((n < W) ? n : W) : 0;
    e_rd1  = (act_m && md_good >= 1) ? en : 0;
    e_rd2  = (act_m && md_good >= 2) ? en : 0;
    e_val  = (e_rd2 > 2) ? e_rd2 - 2 : 0;
    e_lerr = act_m && ((n > W) || ((n < W) && !drop));
    chk("wr_en1_cycles", m_wr - s_wr, en);
    chk("rd_en1_cycles", m_rd1 - s_rd1, e_rd1);
    chk("rd_en2_cycles", m_rd2 - s_rd2, e_rd2);
    chk("win_valid_cycles", m_val - s_val, e_val);
    chk("len_err_pulses", m_lerr - s_lerr, e_lerr);
    if (en > 0) chk("col_cnt_align", m_colbad - s_colbad, 0);
    if (e_val > 0) begin
      chk("valid_start_offset", first_val - first_en, 3);
      chk("valid_contiguous", last_val - first_val + 1, e_val);
    end
    if (e_lerr) chk("len_err_position", lerr_cyc - first_en, en);
    if (e_lerr) md_err = 1'b1;
    else if (act_m && n == W && !drop) md_good++;
    chk("row_cnt", row_cnt, md_good);
    snap_line();
  endtask

  task automatic end_frame(input int idle);
    bit e_done;
    for (int i = 0; i < idle; i++) tick(1'b0, 1'b0);
    @(negedge clk);
    #1;
    e_done = md_trk && !md_err && (md_good >= 2);
    chk("frame_done_pulses", m_done - s_done, e_done);
    chk("fifo_clr_pulses", m_clr - s_clr, md_trk);
    chk("win_vs_cycles", m_vs - s_vs, md_trk ? v_ticks : 0);
    chk("win_hs_vs_valid", m_hsbad - s_hsbad, 0);
    chk("tail_wr_en1", m_wr - s_wr, 0);
    chk("tail_len_err", m_lerr - s_lerr, 0);
    chk("row_cnt_final", row_cnt, md_good);
    snap_all();
  endtask

  task automatic nominal_frame(input int lines);
    start_frame(2);
    for (int i = 0; i < lines; i++) drive_line(W, 2, 1'b0);
    end_frame(3);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    @(negedge clk);
    #1;
    snap_all();

    // Nominal 5-line frame
    nominal_frame(5);

    // Short third line, then a clean frame
    start_frame(2);
    drive_line(W, 2, 1'b0);
    drive_line(W, 2, 1'b0);
    drive_line(W - 1, 2, 1'b0);
    drive_line(W, 2, 1'b0);
    drive_line(W, 2, 1'b0);
    end_frame(3);
    nominal_frame(5);

    // Overlength second line
    start_frame(2);
    drive_line(W, 2, 1'b0);
    drive_line(W + 1, 2, 1'b0);
    drive_line(W, 2, 1'b0);
    end_frame(3);

    // Frame end coincident with the final line end
    start_frame(3);
    drive_line(W, 2, 1'b0);
    drive_line(W, 3, 1'b0);
    drive_line(W, 2, 1'b0);
    drive_line(W, 2, 1'b1);
    end_frame(2);

    // Two-line frame, then a three-line frame (syncs drop with the last line)
    start_frame(2);
    drive_line(W, 2, 1'b0);
    drive_line(W, 2, 1'b1);
    end_frame(2);
    start_frame(2);
    drive_line(W, 2, 1'b0);
    drive_line(W, 2, 1'b0);
    drive_line(W, 2, 1'b1);
    end_frame(2);

    // Asynchronous reset in the middle of RUN line 3
    start_frame(2);
    for (int i = 0; i < 3; i++) drive_line(W, 2, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outs_zero("async_reset_outputs");
    md_trk = 1'b0; md_err = 1'b0; md_good = 0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    snap_all();
    drive_line(2, 2, 1'b0);
    drive_line(W, 2, 1'b0);
    drive_line(W, 2, 1'b0);
    end_frame(3);
    nominal_frame(4);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int nl;
      nl = int'($urandom_range(1, 5));
      start_frame(int'($urandom_range(2, 4)));
      for (int l = 0; l < nl; l++) begin
        int r, n;
        bit last_drop;
        r = int'($urandom_range(0, 9));
        if (r == 7) n = int'($urandom_range(1, W - 1));
        else if (r == 8) n = W + int'($urandom_range(1, 2));
        else n = W;
        last_drop = (l == nl - 1) ? bit'($urandom_range(0, 1)) : 1'b0;
        drive_line(n, int'($urandom_range(2, 4)), last_drop);
      end
      end_frame(int'($urandom_range(2, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
